// File: rtl/mod_codec_config_seq_pkg.sv
// Shared types and constants for the WM8731 power-up configuration sequencer.
package pkg_codec_config;

  // Sequencer states; exported on the top-level o_state debug port.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    RUN   = 3'd2,
    NEXT  = 3'd3,
    FAIL  = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_t;

  // Fault codes reported by mod_i2c_master on o_fault_code.
  localparam logic [3:0] FAULT_NONE      = 4'h0;
  localparam logic [3:0] FAULT_REPEAT    = 4'h1;
  localparam logic [3:0] FAULT_ADDR_NACK = 4'h2;
  localparam logic [3:0] FAULT_REG_NACK  = 4'h3;
  localparam logic [3:0] FAULT_DATA_NACK = 4'h4;
  localparam logic [3:0] FAULT_BAD_STATE = 4'h5;
  localparam logic [3:0] FAULT_TIMEOUT   = 4'hE;
  localparam logic [3:0] FAULT_OK_DONE   = 4'hF;

  // WM8731 register addresses (7-bit).
  localparam logic [6:0] REG_LEFT_LINE_IN  = 7'h00;
  localparam logic [6:0] REG_RIGHT_LINE_IN = 7'h01;
  localparam logic [6:0] REG_LEFT_HP_OUT   = 7'h02;
  localparam logic [6:0] REG_RIGHT_HP_OUT  = 7'h03;
  localparam logic [6:0] REG_ANALOG_PATH   = 7'h04;
  localparam logic [6:0] REG_DIGITAL_PATH  = 7'h05;
  localparam logic [6:0] REG_POWER_DOWN    = 7'h06;
  localparam logic [6:0] REG_DIGITAL_IF    = 7'h07;
  localparam logic [6:0] REG_SAMPLING      = 7'h08;
  localparam logic [6:0] REG_ACTIVE        = 7'h09;
  localparam logic [6:0] REG_RESET         = 7'h0F;

  // A real fault: anything other than "still working" (0) or "finished OK" (F).
  function automatic logic is_fault(input logic [3:0] code);
    return (code != FAULT_NONE) && (code != FAULT_OK_DONE);
  endfunction

endpackage

// File: rtl/mod_codec_config_rom.sv
// Fixed WM8731 power-up table: index -> {register[6:0], data[8:0]}.
module mod_codec_config_rom
  import pkg_codec_config::*;
#(
  parameter int IW = 4
) (
  input  logic [IW-1:0] index,
  output logic [6:0]    register,
  output logic [8:0]    data
);

  logic [15:0] entry;

  // Table lookup; indices past the end read as an all-zero entry.
  always_comb begin
    entry = '0;
    case (int'(index))
      0:       entry = {REG_RESET,         9'h000};
      1:       entry = {REG_LEFT_LINE_IN,  9'h017};
      2:       entry = {REG_RIGHT_LINE_IN, 9'h017};
      3:       entry = {REG_LEFT_HP_OUT,   9'h079};
      4:       entry = {REG_RIGHT_HP_OUT,  9'h079};
      5:       entry = {REG_ANALOG_PATH,   9'h012};
      6:       entry = {REG_DIGITAL_PATH,  9'h000};
      7:       entry = {REG_POWER_DOWN,    9'h000};
      8:       entry = {REG_DIGITAL_IF,    9'h042};
      9:       entry = {REG_SAMPLING,      9'h000};
      10:      entry = {REG_ACTIVE,        9'h001};
      default: entry = '0;
    endcase
  end

  assign register = entry[15:9];
  assign data     = entry[8:0];

endmodule

// File: rtl/mod_codec_config_seq.sv
// WM8731 power-up configuration sequencer. Walks the register table and runs
// one mod_i2c_master write per entry, restarting the master through its
// active-low reset before every attempt, retrying failed writes and latching
// either completion or the failing entry's index and fault code.
//
// Handshake: i_start is a one-cycle request, accepted only while no sequence
// is running (o_busy low). Toward the master, o_i2c_nrst high means an attempt
// is in flight; i_i2c_done/i_i2c_fault_code are only looked at in that window,
// and not during its first two cycles while the master's fault register is
// still uninitialised.
module mod_codec_config_seq
  import pkg_codec_config::*;
#(
  parameter int         NUM_REGS       = 11,
  parameter logic [6:0] I2C_ADDR       = 7'h1A,
  parameter int         MAX_RETRIES    = 3,
  parameter int         HOLD_CYCLES    = 2,
  parameter int         TIMEOUT_CYCLES = 100
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error,
  output logic [$clog2(NUM_REGS)-1:0] o_err_index,
  output logic [3:0]                  o_err_code,
  output logic                        o_i2c_nrst,
  output logic [6:0]                  o_i2c_addr,
  output logic [6:0]                  o_i2c_register,
  output logic [8:0]                  o_i2c_data,
  output logic                        o_i2c_read_not_write,
  input  logic                        i_i2c_done,
  input  logic [3:0]                  i_i2c_fault_code,
  output state_t                      o_state
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_REGS - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ARM  = TW'(2);

  state_t        state;
  logic [IW-1:0] idx;
  logic [RW-1:0] retry;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] timer;
  logic [3:0]    code;
  logic [6:0]    rom_register;
  logic [8:0]    rom_data;

  mod_codec_config_rom #(
    .IW (IW)
  ) u_rom (
    .index    (idx),
    .register (rom_register),
    .data     (rom_data)
  );

  // The master is always addressed at the codec and only ever written.
  assign o_i2c_addr           = I2C_ADDR;
  assign o_i2c_read_not_write = 1'b0;
  assign o_state              = state;

  // Sequencer FSM: hold master in reset, run one write, judge it, advance or retry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= IDLE;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_error        <= 1'b0;
      o_err_index    <= '0;
      o_err_code     <= '0;
      o_i2c_nrst     <= 1'b0;
      o_i2c_register <= '0;
      o_i2c_data     <= '0;
      idx            <= '0;
      retry          <= '0;
      hold_cnt       <= '0;
      timer          <= '0;
      code           <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          o_i2c_nrst <= 1'b0;
          if (i_start) begin
            o_done      <= 1'b0;
            o_error     <= 1'b0;
            o_err_index <= '0;
            o_err_code  <= '0;
            o_busy      <= 1'b1;
            idx         <= '0;
            retry       <= '0;
            hold_cnt    <= '0;
            state       <= HOLD;
          end
        end

        HOLD: begin
          o_i2c_nrst     <= 1'b0;
          o_busy         <= 1'b1;
          o_i2c_register <= rom_register;
          o_i2c_data     <= rom_data;
          if (hold_cnt == HOLD_LAST) begin
            timer      <= '0;
            o_i2c_nrst <= 1'b1;
            state      <= RUN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        RUN: begin
          if (timer < TIMER_ARM) begin
            timer <= timer + 1'b1;
          end else if (is_fault(i_i2c_fault_code)) begin
            code       <= i_i2c_fault_code;
            o_i2c_nrst <= 1'b0;
            state      <= FAIL;
          end else if (i_i2c_done && (i_i2c_fault_code == FAULT_OK_DONE)) begin
            o_i2c_nrst <= 1'b0;
            state      <= NEXT;
          end else if (timer == TIMER_LAST) begin
            code       <= FAULT_TIMEOUT;
            o_i2c_nrst <= 1'b0;
            state      <= FAIL;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        NEXT: begin
          o_i2c_nrst <= 1'b0;
          if (idx == LAST_IDX) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= DONE;
          end else begin
            idx      <= idx + 1'b1;
            retry    <= '0;
            hold_cnt <= '0;
            state    <= HOLD;
          end
        end

        FAIL: begin
          o_i2c_nrst <= 1'b0;
          if (retry < RETRY_MAX) begin
            retry    <= retry + 1'b1;
            hold_cnt <= '0;
            state    <= HOLD;
          end else begin
            o_error     <= 1'b1;
            o_busy      <= 1'b0;
            o_err_index <= idx;
            o_err_code  <= code;
            state       <= ERROR;
          end
        end

        default: begin
          o_i2c_nrst <= 1'b0;
          o_busy     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mod_codec_config_seq.md
Name: mod_codec_config_seq

Overview:
- Power-up configuration sequencer for the WM8731 audio codec.
- Walks a fixed table of register/data pairs and drives mod_i2c_master once per entry.
- Restarts the master for each write by pulsing the master's active-low reset.
- Checks done/fault for every entry, retries failed writes, and reports completion or a latched error to the top level.

Parameters:
- NUM_REGS, 11: number of table entries.
- I2C_ADDR, 7'h1A: codec 7-bit I2C address.
- MAX_RETRIES, 3: extra attempts per entry after the first failure.
- HOLD_CYCLES, 2: cycles the master is held in reset before each attempt.
- TIMEOUT_CYCLES, 100: cycles allowed per attempt before declaring a hang (the master needs about 59).

Ports:
- i_clk  in  1  Same clock as the master's i_i2c_clk (200-800 kHz).
- i_rst  in  1  Reset. Asynchronous, active-high.
- i_start  in  1  Single-cycle pulse that begins the sequence.
- o_busy  out  1  High while the sequence runs.
- o_done  out  1  High after all entries succeed; held until the next start.
- o_error  out  1  High after retries are exhausted; held until the next start.
- o_err_index  out  $clog2(NUM_REGS)  Table index of the failing entry.
- o_err_code  out  4  Last fault code for the failing entry.
- o_i2c_nrst  out  1  To master i_nrst.
- o_i2c_addr  out  7  To master i_i2c_addr.
- o_i2c_register  out  7  To master i_i2c_register.
- o_i2c_data  out  9  To master i_i2c_data.
- o_i2c_read_not_write  out  1  To master i_mode_read_not_write; tied low.
- i_i2c_done  in  1  From master o_done.
- i_i2c_fault_code  in  4  From master o_fault_code.

Behaviour:
- Reset values (while i_rst is high; async assert, sync deassert):
  - state = IDLE.
  - o_busy, o_done, o_error = 0.
  - o_err_index = 0, o_err_code = 0.
  - o_i2c_nrst = 0, which keeps the master in reset.
  - o_i2c_addr = I2C_ADDR; o_i2c_register = 0; o_i2c_data = 0; o_i2c_read_not_write = 0.
  - Index, retry and timer counters = 0.
- Reset mid-sequence aborts immediately. The master is forced into reset the same cycle, and no partial status survives.
- IDLE, DONE, ERROR:
  - o_i2c_nrst = 0.
  - On i_start: clear o_done, o_error, o_err_index and o_err_code; index = 0; retry = 0; go to HOLD.
- HOLD:
  - o_i2c_nrst = 0; o_busy = 1.
  - o_i2c_register and o_i2c_data are registered from ROM[index].
  - Stay HOLD_CYCLES cycles, then go to RUN with timer = 0.
- RUN:
  - o_i2c_nrst = 1; timer increments every cycle.
  - For timer < 2, i_i2c_fault_code and i_i2c_done are ignored (the master's fault register is uninitialised until its first state executes).
  - From timer >= 2, evaluate in this priority order:
    - (a) Fault: i_i2c_fault_code is not 0 and not F. Go to FAIL with code = i_i2c_fault_code.
    - (b) Success: i_i2c_done = 1 and i_i2c_fault_code = F. Go to NEXT.
    - (c) Timeout: timer = TIMEOUT_CYCLES-1. Go to FAIL with code = 4'hE.
- NEXT (one cycle):
  - If index = NUM_REGS-1: go to DONE; o_done = 1, o_busy = 0, o_i2c_nrst = 0.
  - Otherwise: index increments, retry = 0, go to HOLD.
- FAIL (one cycle):
  - If retry < MAX_RETRIES: retry increments; go to HOLD at the same index.
  - Otherwise: go to ERROR; o_error = 1, o_busy = 0, o_err_index = index, o_err_code = code.
- Counters and boundaries:
  - Index never wraps.
  - i_start while o_busy = 1 is ignored.
  - i_start in DONE or ERROR restarts the sequence from index 0.
  - A simultaneous fault and done resolves as a fault.
- Latency: with an ACKing slave, each entry takes HOLD_CYCLES + about 59 + 1 cycles. The full default sequence takes about 682 cycles.
- ROM contents, index: {register, data}:
  - 0: {0x0F, 0x000}, reset.
  - 1: {0x00, 0x017}.
  - 2: {0x01, 0x017}.
  - 3: {0x02, 0x079}.
  - 4: {0x03, 0x079}.
  - 5: {0x04, 0x012}.
  - 6: {0x05, 0x000}.
  - 7: {0x06, 0x000}.
  - 8: {0x07, 0x042}.
  - 9: {0x08, 0x000}.
  - 10: {0x09, 0x001}, activate.

Decomposition:
- Shared package pkg_codec_config:
  - State enum: IDLE, HOLD, RUN, NEXT, FAIL, DONE, ERROR.
  - Master fault-code constants: FAULT_NONE=0, FAULT_REPEAT=1, FAULT_ADDR_NACK=2, FAULT_REG_NACK=3, FAULT_DATA_NACK=4, FAULT_BAD_STATE=5, FAULT_TIMEOUT=E, FAULT_OK_DONE=F.
  - Codec register address constants.
- One sub-module, mod_codec_config_rom: purely combinational index -> {register[6:0], data[8:0]}. Out-of-range indices return {0x00, 0x000}.

Test Plan:
- Full run: reset, then i_start, with a bench slave that ACKs every byte. The master sees 11 transactions in ROM order, the first {0x0F, 0x000} and the last {0x09, 0x001}. o_done rises after the last, with o_error = 0.
- Transient NACK: the slave NACKs the address only on the first attempt at index 3. Index 3 repeats once with identical data, then the sequence completes with o_done = 1.
- Persistent NACK: the slave NACKs the data byte at index 5 forever. Exactly 4 attempts are seen, then o_error = 1, o_err_index = 5, o_err_code = 4.
- Hang: the slave holds i_i2c_done low with fault code 0. After 4 attempts of TIMEOUT_CYCLES each: o_error = 1, o_err_code = 4'hE.
- Reset mid-sequence: assert i_rst during index 6. In the same cycle o_i2c_nrst = 0 and o_busy = 0, and all outputs hold reset values. After reset, i_start runs again from index 0.
- Start handling: an i_start pulse during RUN causes no change. An i_start in DONE clears o_done and restarts from index 0.
